fwd_clk_sampler: RTL and testbench
==================================

# fwd_clk_sampler

Receive-side companion to the forwarded-clock register block: samples a forwarded clock `clkin` and its data bus `din` in the local `clk` domain, with no second clock. Captures one data word per selected `clkin` edge, flags each capture with a one-cycle `valid` strobe, counts captures, and raises `lost` when the forwarded clock stops. Sits at the boundary between a forwarded-clock source and local-clock logic in cosimulation benches.

## Interface
- `WIDTH`, 8, width of `din` and `q`.
- `SYNC_STAGES`, 2, synchronizer depth for `clkin` and `din`. Legal values are 2 and above.
- `CAPTURE_EDGE`, 0, selects the `clkin` transition that captures data: 0 = falling, 1 = rising. The source launches data on the `clkin` rising edge, so the default is 0.
- `TIMEOUT`, 64, number of consecutive `clk` cycles without a capture edge before `lost` asserts. Legal values are 2 and above.
- `CNT_WIDTH`, 16, width of `edge_count`.

Ports:
- `clk` input 1: local sampling clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `clkin` input 1: forwarded clock, treated as data. Its frequency is at most `clk`/4.
- `din` input `WIDTH`: forwarded data, launched by the source on the `clkin` rising edge.
- `q` output `WIDTH`: last captured word.
- `valid` output 1: one-cycle strobe, high in the cycle `q` takes a new word.
- `edge_count` output `CNT_WIDTH`: number of captures since reset.
- `lost` output 1: forwarded clock absent.

## Operation
- **Synchronizers.** `clkin` and `din` each pass through a `SYNC_STAGES`-deep flop chain of equal length, so they stay aligned. One further register `prev` holds the previous last-stage value of `clkin`.
- **Edge detect.** This is combinational on the last stage and `prev`:
  - rising edge = last stage high and `prev` low;
  - falling edge = last stage low and `prev` high.
  - Only the edge selected by `CAPTURE_EDGE` counts as a capture edge.
- **On each capture edge:**
  - `q` takes the last-stage `din` value;
  - `valid` is high for exactly one cycle;
  - `edge_count` increments, wrapping from all-ones to 0.
- **Idle counter.** `idle_cnt` is `ceil(log2(TIMEOUT+1))` bits wide.
  - It clears to 0 on a capture edge.
  - Otherwise it increments, saturating at `TIMEOUT`.
- **State machine.** States are WAIT, RUN and LOST. `lost` is high only in LOST.
  - WAIT is the state after reset.
  - WAIT or RUN moves to LOST when there is no capture edge and `idle_cnt` equals `TIMEOUT`-1.
  - Any state moves to RUN on a capture edge.
  - LOST is held while no capture edge occurs.
- **Simultaneous events.** A capture edge in the same cycle as the timeout condition takes priority: the next state is RUN and `idle_cnt` clears.
- **Reset values.** All of the following clear asynchronously whenever `reset` is high, including in the middle of a capture:
  - `q` = 0, `valid` = 0, `edge_count` = 0, `lost` = 0;
  - state = WAIT, `idle_cnt` = 0;
  - all synchronizer stages = 0, `prev` = 0.
- **First edge after reset.** Because the synchronizers reset to 0, a `clkin` held high through reset release produces one rising edge after `SYNC_STAGES` cycles.
- **Non-selected edge.** A transition on the non-selected `clkin` edge has no effect on any output, and does not clear `idle_cnt`.

## Timing
- **Capture latency.** Let the first `clk` rising edge that samples the capture-edge level of `clkin` be edge n.
  - `valid`, the new `q` and the incremented `edge_count` are all visible after edge n+`SYNC_STAGES`.
  - `q` equals `din` as sampled at edge n.
- **Strobe width.** `valid` is exactly one cycle wide. No two `valid` pulses are closer than 2 cycles, which follows from the `clk`/4 limit on `clkin`.
- **Timeout.** If `valid` is high in cycle c and no further capture edge occurs, `lost` is high from cycle c+`TIMEOUT`.
  - From reset release, with no capture edge, `lost` rises after `TIMEOUT` cycles.
- **Recovery.** In LOST, `lost` falls in the same cycle that `valid` pulses.
- **Data requirement.** `din` must be stable for at least 2 `clk` periods around the selected `clkin` edge. This is the source's responsibility.

## Test plan
- **Basic capture.** `clkin` = `clk`/8 with `din` incrementing on each `clkin` rise, default parameters → each `valid` carries the word launched on the preceding rise; `edge_count` reads 1, 2, 3…; first `valid` is 2 cycles after the first sampled fall.
- **Edge select and latency.** `CAPTURE_EDGE`=1, `SYNC_STAGES`=3 → `valid` is 3 cycles after the first sampled rise; `q` equals `din` at that sample; falls produce no `valid`.
- **Timeout and recovery.** `TIMEOUT`=64: stop `clkin` after a `valid` in cycle c → `lost` = 0 through cycle c+63 and 1 at c+64; restart `clkin` → `lost` falls with the first `valid`, and state returns to RUN.
- **Wrap.** `CNT_WIDTH`=4, 17 captures → `edge_count` goes 15 → 0 → 1.
- **Reset mid-operation.** Assert `reset` in the cycle `valid` is high → `q`, `valid`, `edge_count` and `lost` are all 0 immediately; the first `valid` after release follows the full latency.
- **Glitch-free hold.** Hold `clkin` high through reset release with `CAPTURE_EDGE`=1 → exactly one `valid`, `SYNC_STAGES` cycles after release; no further `valid` while `clkin` stays high.

Source files
------------

// File: rtl/fwd_clk_sampler.sv
// fwd_clk_sampler: samples a forwarded clock (clkin) and its data bus (din)
// in the local clk domain and captures one word per selected clkin edge.
// Ports: clk/reset (async, active-high); clkin/din forwarded inputs;
//   q = last captured word, valid = one-cycle capture strobe,
//   edge_count = captures since reset, lost = forwarded clock absent.
module fwd_clk_sampler #(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int CAPTURE_EDGE = 0,
  parameter int TIMEOUT      = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clkin,
  input  logic [WIDTH-1:0]     din,
  output logic [WIDTH-1:0]     q,
  output logic                 valid,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 lost
);

  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_TRIP = IW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_RUN,
    ST_LOST
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [WIDTH-1:0]       din_sync [SYNC_STAGES];
  logic                   prev;
  logic                   last;
  logic                   cap;
  logic [IW-1:0]          idle_cnt;

  // clkin and din run through chains of identical depth so the data word
  // seen at the last stage lines up with the clkin level beside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      prev     <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) din_sync[i] <= '0;
    end else begin
      clk_sync    <= {clk_sync[SYNC_STAGES-2:0], clkin};
      prev        <= clk_sync[SYNC_STAGES-1];
      din_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) din_sync[i] <= din_sync[i-1];
    end
  end

  assign last = clk_sync[SYNC_STAGES-1];

  // Only the selected transition counts; the other edge is ignored entirely.
  always_comb begin
    if (CAPTURE_EDGE != 0) cap = last & ~prev;
    else                   cap = ~last & prev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q          <= '0;
      valid      <= 1'b0;
      edge_count <= '0;
    end else begin
      valid <= cap;
      if (cap) begin
        q          <= din_sync[SYNC_STAGES-1];
        edge_count <= edge_count + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (cap) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_nxt;
  end

  // A capture edge wins over a timeout landing in the same cycle, so lost
  // drops in the same cycle valid pulses.
  always_comb begin
    state_nxt = state;
    lost      = 1'b0;
    if (cap) begin
      state_nxt = ST_RUN;
    end else if (state != ST_LOST && idle_cnt == IDLE_TRIP) begin
      state_nxt = ST_LOST;
    end
    if (state == ST_LOST) lost = 1'b1;
  end

endmodule

// File: tb/tb_fwd_clk_sampler.sv
module tb_fwd_clk_sampler;

  logic       clk = 1'b0;
  logic       reset;
  logic       clkin;
  logic [7:0] din;

  logic [7:0]  q0, q1;
  logic        valid0, valid1, lost0, lost1;
  logic [15:0] count0;
  logic [3:0]  count1;

  int         vecs = 0;
  int         errs = 0;
  int         n0 = 0;
  logic [3:0] n1 = 4'd0;

  always #5 clk = ~clk;

  // Default build: falling-edge capture, 2 stages, timeout 64.
  fwd_clk_sampler u0 (
    .clk(clk), .reset(reset), .clkin(clkin), .din(din),
    .q(q0), .valid(valid0), .edge_count(count0), .lost(lost0)
  );

  // Rising-edge capture, 3 stages, 4-bit counter, short timeout that exactly
  // matches the capture spacing of an 8-cycle clkin period.
  fwd_clk_sampler #(
    .WIDTH(8), .SYNC_STAGES(3), .CAPTURE_EDGE(1), .TIMEOUT(8), .CNT_WIDTH(4)
  ) u1 (
    .clk(clk), .reset(reset), .clkin(clkin), .din(din),
    .q(q1), .valid(valid1), .edge_count(count1), .lost(lost1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clkin period of 8 clk cycles: rise with new din, fall after 4 cycles.
  // u1 (rise, 3 stages) strobes at tick 4; u0 (fall, 2 stages) at tick 7.
  task automatic period(input logic [7:0] w, input logic l0, input logic l1);
    clkin = 1'b1;
    din   = w;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("valid0", 32'(valid0), 32'(k == 7));
      chk("valid1", 32'(valid1), 32'(k == 4));
      chk("lost0", 32'(lost0), 32'(l0 && k < 7));
      chk("lost1", 32'(lost1), 32'(l1 && k < 4));
      if (k == 4) begin
        n1 = n1 + 4'd1;
        chk("q1", 32'(q1), 32'(w));
        chk("count1", 32'(count1), 32'(n1));
        clkin = 1'b0;
      end
      if (k == 7) begin
        n0++;
        chk("q0", 32'(q0), 32'(w));
        chk("count0", 32'(count0), 32'(n0));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    clkin = 1'b0;
    din   = 8'h00;
    tick();
    tick();
    chk("rst_q0", 32'(q0), 32'h0);
    chk("rst_valid0", 32'(valid0), 32'h0);
    chk("rst_count0", 32'(count0), 32'h0);
    chk("rst_lost0", 32'(lost0), 32'h0);
    chk("rst_q1", 32'(q1), 32'h0);
    chk("rst_valid1", 32'(valid1), 32'h0);
    chk("rst_count1", 32'(count1), 32'h0);
    chk("rst_lost1", 32'(lost1), 32'h0);

    // Basic capture with incrementing data; 17 captures wraps u1's counter.
    reset = 1'b0;
    for (int p = 0; p < 17; p++) period(8'(p + 1), 1'b0, 1'b0);

    // Timeout: u0 last strobed at c0 (now c0+1), u1 at c1 (now c1+4).
    repeat (3) tick();
    chk("lost1_c1p7", 32'(lost1), 32'h0);
    tick();
    chk("lost1_c1p8", 32'(lost1), 32'h1);
    repeat (58) tick();
    chk("lost0_c0p63", 32'(lost0), 32'h0);
    tick();
    chk("lost0_c0p64", 32'(lost0), 32'h1);
    chk("lost1_held", 32'(lost1), 32'h1);
    chk("valid0_idle", 32'(valid0), 32'h0);

    // Recovery: lost falls with the first strobe, then stays low in RUN.
    period(8'hA5, 1'b1, 1'b1);
    period(8'h3C, 1'b0, 1'b0);

    // Reset in the cycle u1's valid is high, with clkin held high.
    clkin = 1'b1;
    din   = 8'h5A;
    repeat (4) tick();
    chk("valid1_pre_rst", 32'(valid1), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_q0", 32'(q0), 32'h0);
    chk("mid_valid0", 32'(valid0), 32'h0);
    chk("mid_count0", 32'(count0), 32'h0);
    chk("mid_lost0", 32'(lost0), 32'h0);
    chk("mid_q1", 32'(q1), 32'h0);
    chk("mid_valid1", 32'(valid1), 32'h0);
    chk("mid_count1", 32'(count1), 32'h0);
    chk("mid_lost1", 32'(lost1), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // clkin high through release: u1 sees exactly one rise, u0 nothing.
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("hold_valid1", 32'(valid1), 32'(k == 4));
      chk("hold_valid0", 32'(valid0), 32'h0);
      if (k == 4) begin
        chk("hold_q1", 32'(q1), 32'h5A);
        chk("hold_count1", 32'(count1), 32'h1);
      end
    end
    chk("hold_count1_end", 32'(count1), 32'h1);
    chk("hold_count0_end", 32'(count0), 32'h0);

    // First fall after release: full u0 latency, ignored by u1.
    clkin = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      tick();
      chk("fall_valid0", 32'(valid0), 32'(k == 13));
      chk("fall_valid1", 32'(valid1), 32'h0);
      if (k == 13) begin
        chk("fall_q0", 32'(q0), 32'h5A);
        chk("fall_count0", 32'(count0), 32'h1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
